// File: rtl/h14tx_period_sched.sv
// Period scheduler for the HDMI 1.4 transmitter: registered period, CTL, packet slot and
// packet-consume pulse, derived from the timing generator's x/y and a single packet source.
module h14tx_period_sched #(
  parameter int BitWidth     = 11,
  parameter int BitHeight    = 10,
  parameter int HActive      = 1280,
  parameter int HTotal       = 1650,
  parameter int VActive      = 720,
  parameter int VTotal       = 750,
  parameter int IslandOffset = 4,
  parameter int MaxPackets   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BitWidth-1:0]  x,
  input  logic [BitHeight-1:0] y,
  input  logic                 pkt_valid,
  output logic                 pkt_ready,
  output logic [2:0]           period,
  output logic [3:0]           ctl,
  output logic [4:0]           slot
);

  if ((HActive + IslandOffset + 12 + 32*MaxPackets + 12 > HTotal - 10) || (IslandOffset < 4))
  begin : g_bad_cfg
    $error("h14tx_period_sched: island does not fit in horizontal blanking");
  end

  localparam int NW = (MaxPackets < 2) ? 1 : $clog2(MaxPackets + 1);
  localparam logic [BitWidth-1:0]  XDec  = BitWidth'(HActive + IslandOffset);
  localparam logic [BitWidth-1:0]  XPreS = BitWidth'(HTotal - 10);
  localparam logic [BitWidth-1:0]  XGbS  = BitWidth'(HTotal - 2);
  localparam logic [BitWidth-1:0]  XLast = BitWidth'(HTotal - 1);
  localparam logic [BitWidth-1:0]  XAct  = BitWidth'(HActive);
  localparam logic [BitHeight-1:0] YAct  = BitHeight'(VActive);
  localparam logic [BitHeight:0]   YnTot = (BitHeight+1)'(VTotal);
  localparam logic [BitHeight:0]   YnAct = (BitHeight+1)'(VActive);
  localparam logic [NW-1:0]        NMax  = NW'(MaxPackets);

  localparam logic [2:0] P_CTRL = 3'd0, P_VPRE = 3'd1, P_VGB = 3'd2, P_VID = 3'd3,
                         P_DPRE = 3'd4, P_DGBL = 3'd5, P_DATA = 3'd6, P_DGBT = 3'd7;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_GBL, S_DATA, S_GBT} st_e;

  st_e             st_q, st_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [NW-1:0]   npkt_q, npkt_d;
  logic            pre_run_q, pre_run_d;
  logic            seen_q, seen_d;
  logic            rdy_q, rdy_d;
  logic [2:0]      per_q, per_d;
  logic [3:0]      ctl_q, ctl_d;
  logic [4:0]      slot_q, slot_d;

  logic [BitHeight:0] yn;
  logic               succ, in_pre, in_gb;

  always_comb begin
    yn     = {1'b0, y} + 1'b1;
    // Line VTotal-1 wraps to line 0, which is always active.
    succ   = (yn == YnTot) ? 1'b1 : (yn < YnAct);
    in_pre = succ && (x >= XPreS) && (x < XGbS);
    in_gb  = succ && (x >= XGbS) && (x <= XLast);
  end

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    npkt_d = npkt_q;
    rdy_d  = 1'b0;
    case (st_q)
      S_IDLE: if (x == XDec && pkt_valid) begin st_d = S_PRE; cnt_d = '0; end
      S_PRE:  if (cnt_q == 5'd7) begin st_d = S_GBL; cnt_d = '0; end else cnt_d = cnt_q + 1'b1;
      S_GBL:
        if (cnt_q == 5'd1) begin
          st_d = S_DATA; cnt_d = '0; npkt_d = NW'(1); rdy_d = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      S_DATA:
        if (cnt_q == 5'd31) begin
          if (pkt_valid && npkt_q < NMax) begin
            cnt_d = '0; npkt_d = npkt_q + 1'b1; rdy_d = 1'b1;
          end else begin
            st_d = S_GBT; cnt_d = '0;
          end
        end else cnt_d = cnt_q + 1'b1;
      S_GBT:  if (cnt_q == 5'd1) begin st_d = S_IDLE; cnt_d = '0; end else cnt_d = cnt_q + 1'b1;
      default: begin st_d = S_IDLE; cnt_d = '0; end
    endcase

    // Video is only allowed after a preamble that started at its first cycle.
    pre_run_d = (in_pre || in_gb) ? ((x == XPreS) ? 1'b1 : pre_run_q) : 1'b0;
    if (in_gb && x == XLast && pre_run_q) seen_d = 1'b1;
    else if (x == XAct)                   seen_d = 1'b0;
    else                                  seen_d = seen_q;

    case (st_d)
      S_PRE:   per_d = P_DPRE;
      S_GBL:   per_d = P_DGBL;
      S_DATA:  per_d = P_DATA;
      S_GBT:   per_d = P_DGBT;
      default:
        if (in_pre)                          per_d = P_VPRE;
        else if (in_gb)                      per_d = P_VGB;
        else if (x < XAct && y < YAct && seen_q) per_d = P_VID;
        else                                 per_d = P_CTRL;
    endcase
    ctl_d  = (per_d == P_VPRE) ? 4'b0001 : (per_d == P_DPRE) ? 4'b0101 : 4'b0000;
    slot_d = (st_d == S_DATA) ? cnt_d : 5'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= S_IDLE;
      cnt_q     <= '0;
      npkt_q    <= '0;
      pre_run_q <= 1'b0;
      seen_q    <= 1'b0;
      rdy_q     <= 1'b0;
      per_q     <= P_CTRL;
      ctl_q     <= 4'b0000;
      slot_q    <= '0;
    end else begin
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      npkt_q    <= npkt_d;
      pre_run_q <= pre_run_d;
      seen_q    <= seen_d;
      rdy_q     <= rdy_d;
      per_q     <= per_d;
      ctl_q     <= ctl_d;
      slot_q    <= slot_d;
    end
  end

  assign pkt_ready = rdy_q;
  assign period    = per_q;
  assign ctl       = ctl_q;
  assign slot      = slot_q;

endmodule

// File: tb/tb_h14tx_period_sched.sv
// Scoreboard bench for h14tx_period_sched: a position-based expectation per sampled (x,y)
// is queued when driven and compared one cycle later.
module tb_h14tx_period_sched;
  localparam int HT = 1650, HA = 1280, VT = 750, VA = 720, DEC = 1284;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] x = '0;
  logic [9:0]  y = '0;
  logic        pkt_valid = 1'b0;
  logic        pkt_ready;
  logic [2:0]  period;
  logic [3:0]  ctl;
  logic [4:0]  slot;

  h14tx_period_sched dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .pkt_valid(pkt_valid),
    .pkt_ready(pkt_ready), .period(period), .ctl(ctl), .slot(slot)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  logic [12:0] exp_q[$];
  string       tag_q[$];
  logic [12:0] got;
  bit          vok_next = 1'b0;

  assign got = {period, ctl, slot, pkt_ready};

  task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got period=%0d ctl=%b slot=%0d rdy=%b, expected period=%0d ctl=%b slot=%0d rdy=%b",
               tag, obs[12:10], obs[9:6], obs[5:1], obs[0], exp[12:10], exp[9:6], exp[5:1], exp[0]);
    end
  endtask

  // npk: packets expected on this line's island (0 = none); vok: preceding preamble was complete.
  function automatic logic [12:0] model(input int xx, input int yy, input int npk, input bit vok);
    logic [2:0] p;
    logic [3:0] c;
    logic [4:0] s;
    logic       r;
    bit         succ;
    int         d;
    p = 3'd0; s = 5'd0; r = 1'b0;
    succ = ((yy + 1) % VT) < VA;
    d = xx - DEC;
    if (npk > 0 && d >= 0 && d < 8)                       p = 3'd4;
    else if (npk > 0 && d >= 8 && d < 10)                 p = 3'd5;
    else if (npk > 0 && d >= 10 && d < 10 + 32*npk) begin
      p = 3'd6; s = 5'((d - 10) % 32); r = (s == 5'd0);
    end
    else if (npk > 0 && d >= 10 + 32*npk && d < 12 + 32*npk) p = 3'd7;
    else if (succ && xx >= HT-10 && xx <= HT-3)           p = 3'd1;
    else if (succ && xx >= HT-2)                          p = 3'd2;
    else if (xx < HA && yy < VA && vok)                   p = 3'd3;
    c = (p == 3'd1) ? 4'b0001 : (p == 3'd4) ? 4'b0101 : 4'b0000;
    return {p, c, s, r};
  endfunction

  task automatic step(input int xx, input int yy, input bit pv, input int npk, input bit vok);
    @(negedge clk);
    if (exp_q.size() > 0) chk(tag_q.pop_front(), got, exp_q.pop_front());
    x = 11'(xx);
    y = 10'(yy);
    pkt_valid = pv;
    exp_q.push_back(model(xx, yy, npk, vok));
    tag_q.push_back($sformatf("y%0d_x%0d", yy, xx));
  endtask

  // mode 0: no packets; 1: pkt_valid held; 2: valid until first consume; 3: valid rises at x=1285
  task automatic run_line(input int yy, input int mode, input int x0 = 0, input int x1 = HT - 1);
    int npk;
    bit vok;
    vok = vok_next;
    npk = (mode == 1) ? 2 : (mode == 2) ? 1 : 0;
    for (int xx = x0; xx <= x1; xx++) begin
      bit pv;
      pv = (mode == 1) || (mode == 2 && xx < 1295) || (mode == 3 && xx >= 1285);
      step(xx, yy, pv, npk, vok);
    end
    vok_next = ((yy + 1) % VT) < VA;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) begin
      @(negedge clk);
      chk("reset_state", got, 13'd0);
    end
    rst_n = 1'b1;

    run_line(748, 0);
    run_line(749, 0);
    run_line(0, 0);
    run_line(1, 0);
    run_line(10, 1);
    run_line(11, 2);
    run_line(12, 3);
    run_line(13, 1);
    run_line(718, 0);
    run_line(719, 0);
    run_line(720, 1);
    run_line(748, 0);
    run_line(749, 0);
    run_line(0, 0);

    // Reset in the middle of an island's packet data.
    run_line(50, 1, 0, 1300);
    @(negedge clk);
    if (exp_q.size() > 0) chk(tag_q.pop_front(), got, exp_q.pop_front());
    rst_n = 1'b0;
    #1;
    chk("reset_async", got, 13'd0);
    x = 11'd200; y = 10'd100; pkt_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("reset_hold", got, 13'd0);
    end
    rst_n = 1'b1;
    exp_q.push_back(model(200, 100, 0, 1'b0));
    tag_q.push_back("y100_x200");
    vok_next = 1'b0;
    run_line(100, 0, 201);
    run_line(101, 0);

    @(negedge clk);
    while (exp_q.size() > 0) chk(tag_q.pop_front(), got, exp_q.pop_front());

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/h14tx_period_sched.md
H14TX_PERIOD_SCHED -- requirements
Module: h14tx_period_sched

Interface
REQ-001 SHALL have parameter BitWidth, default 11, width of x.
REQ-002 SHALL have parameter BitHeight, default 10, width of y.
REQ-003 SHALL have parameters HActive, HTotal, VActive and VTotal, defaults 1280, 1650, 720 and 750.
REQ-004 SHALL have parameter IslandOffset, default 4: number of cycles after HActive at which the island decision is made.
REQ-005 SHALL have parameter MaxPackets, default 2: maximum number of packets per data island.
REQ-006 SHALL have port clk, input, 1 bit: the single clock.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port x, input, BitWidth bits: current pixel column from the timing generator.
REQ-009 SHALL have port y, input, BitHeight bits: current line.
REQ-010 SHALL have port pkt_valid, input, 1 bit: packet source has a 32-cycle packet pending.
REQ-011 SHALL have port pkt_ready, output, 1 bit: one-cycle pulse when a packet slot begins (consume).
REQ-012 SHALL have port period, output, 3 bits: 0 CTRL, 1 VID_PRE, 2 VID_GB, 3 VIDEO, 4 DI_PRE, 5 DI_GB_LEAD, 6 DI_DATA, 7 DI_GB_TRAIL.
REQ-013 SHALL have port ctl, output, 4 bits: CTL3..CTL0 values for channels 1/2 during control and preamble.
REQ-014 SHALL have port slot, output, 5 bits: cycle index 0..31 within the current packet, and 0 outside DI_DATA.

Function
REQ-015 SHALL register all outputs, so that each output reflects the x and y values sampled on the previous cycle (latency 1).
REQ-016 SHALL define a line as having an active successor when ((y+1) mod VTotal) < VActive.
REQ-017 SHALL output VID_PRE for sampled x in HTotal-10..HTotal-3 on lines that have an active successor, then VID_GB for x in HTotal-2..HTotal-1, then VIDEO while x<HActive and y<VActive.
REQ-018 SHALL, at sampled x == HActive+IslandOffset on any line, start an island when pkt_valid=1: DI_PRE for 8 cycles, DI_GB_LEAD for 2 cycles, then DI_DATA.
REQ-019 SHALL, at that decision point with pkt_valid=0, remain in CTRL for the rest of the blanking; there is no retry on the same line.
REQ-020 SHALL make each DI_DATA packet exactly 32 cycles, with slot counting 0..31 and pkt_ready=1 only on slot 0.
REQ-021 SHALL ignore pkt_valid after slot 0; a packet in progress is never truncated.
REQ-022 SHALL, at the end of a packet (slot 31), continue with the next packet if pkt_valid=1 and packets-issued<MaxPackets; otherwise it SHALL output DI_GB_TRAIL for 2 cycles, then CTRL.
REQ-023 SHALL drive ctl as follows: 0001 in VID_PRE, 0101 in DI_PRE, 0000 in all other periods.
REQ-024 SHALL fail elaboration unless HActive+IslandOffset+12+32*MaxPackets+12 <= HTotal-10 and IslandOffset>=4; as a result, islands never overlap video preambles.
REQ-025 SHALL enter VIDEO only when it is preceded by a complete VID_PRE+VID_GB sequence; otherwise the active region outputs CTRL until the next line's preamble.
REQ-026 SHALL compute the next-line wrap correctly at y=VTotal-1, where the successor is line 0.

Reset
REQ-027 SHALL, while rst_n=0, force period=CTRL, ctl=0000, slot=0 and pkt_ready=0, clear the packet count, and clear the preamble-seen flag.
REQ-028 SHALL not resume an island or video period that was interrupted by reset; after release it waits for the next decision point or preamble window.

Verification
REQ-029 SHALL be verified with this scenario: default parameters, pkt_valid=0, run a full frame -> period=VIDEO exactly 1280x720 cycles, VID_PRE 8 cycles at sampled x 1640..1647 on y=749 and y=0..718, and no DI_* periods.
REQ-030 SHALL be verified with this scenario: pkt_valid held at 1 on line 10 -> DI_PRE at sampled x=1284..1291, DI_GB_LEAD at 1292..1293, DI_DATA at 1294..1357 with pkt_ready pulses at 1294 and 1326, DI_GB_TRAIL at 1358..1359, then CTRL.
REQ-031 SHALL be verified with this scenario: pkt_valid=1 only until the first pkt_ready -> exactly one packet, with DI_GB_TRAIL starting at sampled x=1326.
REQ-032 SHALL be verified with this scenario: pkt_valid rising at sampled x=1285 -> no island on that line and an island on the next line.
REQ-033 SHALL be verified with this scenario: rst_n asserted mid-DI_DATA, released on y=100 with x=200 -> outputs go to reset values immediately, CTRL persists through the rest of line 100's active region, and VIDEO resumes on line 101 after a full preamble.
REQ-034 SHALL be verified with this scenario: on line 720 (vertical blanking) with pkt_valid=1 -> island occurs, and no VID_PRE on lines 719..748.
